// File: rtl/ttlock_key_unit.sv
// TTLock key unit: serial key load and check, fail counter with lockout, and a TTLock-gated registered datapath.
// Define TTLOCK_KEY_PARITY_EN to add a trailing even-parity bit to each key load and a parity_err output.
module ttlock_key_unit #(
  parameter int unsigned         KEY_W    = 32,
  parameter logic [KEY_W-1:0]    SECRET   = KEY_W'(32'hA5C3_0F96),
  parameter int unsigned         DATA_W   = 8,
  parameter logic [DATA_W-1:0]   PROT_PAT = DATA_W'(8'h3C),
  parameter int unsigned         MAX_FAIL = 3,
  parameter int unsigned         CNT_W    = $clog2(MAX_FAIL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic              key_bit,
  output logic              key_ready,
  input  logic              relock,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout,
  output logic              unlocked,
  output logic              lockout,
  output logic              key_fail,
  output logic [CNT_W-1:0]  fail_cnt
`ifdef TTLOCK_KEY_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned BC_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              key_fail_q, key_fail_d;
  logic              par_err_q, par_err_d;
  logic              dout_valid_q;
  logic [DATA_W-1:0] dout_q;
  logic              accept;
  logic [KEY_W-1:0]  key_shift;

  assign accept    = key_valid & key_ready;
  assign key_shift = {key_q[KEY_W-2:0], key_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      bit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      key_fail_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      bit_cnt_q  <= bit_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      key_fail_q <= key_fail_d;
      par_err_q  <= par_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    bit_cnt_d  = bit_cnt_q;
    fail_cnt_d = fail_cnt_q;
    key_fail_d = 1'b0;
    par_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          key_d     = key_shift;
          bit_cnt_d = BC_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
`ifdef TTLOCK_KEY_PARITY_EN
          // Parity bit is checked against the full key but never shifted in.
          if (bit_cnt_q == BC_W'(KEY_W)) begin
            bit_cnt_d = '0;
            if (^{key_q, key_bit}) begin
              state_d   = IDLE;
              key_d     = '0;
              par_err_d = 1'b1;
            end else begin
              state_d = CHECK;
            end
          end else begin
            key_d     = key_shift;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
`else
          key_d = key_shift;
          if (bit_cnt_q == BC_W'(KEY_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
`endif
        end
      end
      CHECK: begin
        if (key_q == SECRET) begin
          state_d = UNLOCKED;
        end else begin
          key_fail_d = 1'b1;
          fail_cnt_d = (fail_cnt_q == MAX_C) ? fail_cnt_q : fail_cnt_q + 1'b1;
          if (fail_cnt_d == MAX_C) begin
            state_d = LOCKOUT;
          end else begin
            state_d = IDLE;
            key_d   = '0;
          end
        end
      end
      UNLOCKED: begin
        if (relock) begin
          state_d = IDLE;
          key_d   = '0;
        end
      end
      LOCKOUT: ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_ready = 1'b0;
    unlocked  = 1'b0;
    lockout   = 1'b0;
    unique case (state_q)
      IDLE, LOAD: key_ready = 1'b1;
      UNLOCKED:   unlocked  = 1'b1;
      LOCKOUT:    lockout   = 1'b1;
      default: ;
    endcase
  end

  // Datapath sees the pre-edge unlocked value, so a simultaneous relock still passes this word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      dout_valid_q <= din_valid;
      if (din_valid) begin
        dout_q <= din ^ {DATA_W{~unlocked & (din == PROT_PAT)}};
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign key_fail   = key_fail_q;
  assign fail_cnt   = fail_cnt_q;
`ifdef TTLOCK_KEY_PARITY_EN
  assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_ttlock_key_unit.sv
// Directed self-checking bench for ttlock_key_unit; covers parity checks when TTLOCK_KEY_PARITY_EN is defined.
module tb_ttlock_key_unit;

  localparam logic [31:0] GOOD = 32'hA5C3_0F96;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid, key_bit, key_ready, relock;
  logic       din_valid, dout_valid;
  logic [7:0] din, dout;
  logic       unlocked, lockout, key_fail;
  logic [1:0] fail_cnt;
`ifdef TTLOCK_KEY_PARITY_EN
  logic       parity_err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  ttlock_key_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_ready  (key_ready),
    .relock     (relock),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .key_fail   (key_fail),
    .fail_cnt   (fail_cnt)
`ifdef TTLOCK_KEY_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Drives the top n bits of k MSB first; returns at the negedge after the last-bit edge.
  task automatic send_bits(input logic [31:0] k, input int n, input bit gaps);
    for (int i = 31; i > 31 - n; i--) begin
      if (gaps && (i % 5 == 0)) begin
        key_valid = 1'b0;
        @(negedge clk);
      end
      key_valid = 1'b1;
      key_bit   = k[i];
      @(negedge clk);
    end
    key_valid = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] k, input bit gaps, input bit bad_par);
    send_bits(k, 32, gaps);
`ifdef TTLOCK_KEY_PARITY_EN
    key_valid = 1'b1;
    key_bit   = (^k) ^ bad_par;
    @(negedge clk);
    key_valid = 1'b0;
`else
    if (bad_par) $display("note: parity request ignored in this build");
`endif
  endtask

  task automatic data(input logic [7:0] d, input logic [7:0] exp, input string tag);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check({tag, "_v"}, {31'd0, dout_valid}, 32'd1);
    check(tag, {24'd0, dout}, {24'd0, exp});
  endtask

  task automatic do_reset(input int edges);
    rst_n = 1'b0;
    for (int i = 0; i < edges; i++) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with random inputs applied
    rst_n     = 1'b0;
    key_valid = 1'($urandom);
    key_bit   = 1'($urandom);
    relock    = 1'($urandom);
    din_valid = 1'($urandom);
    din       = 8'($urandom);
    @(negedge clk);
    @(negedge clk);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dv", {31'd0, dout_valid}, 32'd0);
    check("rst_unl", {31'd0, unlocked}, 32'd0);
    check("rst_lock", {31'd0, lockout}, 32'd0);
    check("rst_kf", {31'd0, key_fail}, 32'd0);
    check("rst_ready", {31'd0, key_ready}, 32'd1);
    check("rst_fcnt", {30'd0, fail_cnt}, 32'd0);
    key_valid = 1'b0; key_bit = 1'b0; relock = 1'b0; din_valid = 1'b0; din = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Locked datapath
    data(8'h3C, 8'hC3, "lk_prot");
    data(8'h3D, 8'h3D, "lk_pass");
    @(negedge clk);
    check("dv_drop", {31'd0, dout_valid}, 32'd0);
    check("dout_hold", {24'd0, dout}, 32'h3D);

    // Correct key with gaps
    send_key(GOOD, 1'b1, 1'b0);
    check("chk_unl0", {31'd0, unlocked}, 32'd0);
    check("chk_rdy0", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    check("unl_1", {31'd0, unlocked}, 32'd1);
    check("unl_kf", {31'd0, key_fail}, 32'd0);
    data(8'h3C, 8'h3C, "ul_prot");

    // Relock together with a data word: word uses pre-edge unlocked state
    relock = 1'b1;
    data(8'h3C, 8'h3C, "rl_same");
    relock = 1'b0;
    check("rl_unl", {31'd0, unlocked}, 32'd0);
    check("rl_fcnt", {30'd0, fail_cnt}, 32'd0);
    data(8'h3C, 8'hC3, "rl_prot");

    // Three wrong keys
    for (int t = 1; t <= 3; t++) begin
      send_key(32'h0, 1'b0, 1'b0);
      check("wk_kf0", {31'd0, key_fail}, 32'd0);
      @(negedge clk);
      check("wk_kf", {31'd0, key_fail}, 32'd1);
      check("wk_fcnt", {30'd0, fail_cnt}, t);
      check("wk_lock", {31'd0, lockout}, (t == 3) ? 32'd1 : 32'd0);
      check("wk_rdy", {31'd0, key_ready}, (t == 3) ? 32'd0 : 32'd1);
      @(negedge clk);
      check("wk_kf_end", {31'd0, key_fail}, 32'd0);
    end

    // Lockout ignores a correct key and relock
    send_key(GOOD, 1'b0, 1'b0);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    @(negedge clk);
    check("lo_unl", {31'd0, unlocked}, 32'd0);
    check("lo_lock", {31'd0, lockout}, 32'd1);
    check("lo_fcnt", {30'd0, fail_cnt}, 32'd3);
    data(8'h3C, 8'hC3, "lo_prot");
    do_reset(1);
    check("lo_rst", {31'd0, lockout}, 32'd0);
    check("lo_rst_f", {30'd0, fail_cnt}, 32'd0);

    // Reset mid-load discards the partial key
    send_bits(GOOD, 16, 1'b0);
    do_reset(1);
    send_key(GOOD, 1'b0, 1'b0);
    @(negedge clk);
    check("ml_unl", {31'd0, unlocked}, 32'd1);
    check("ml_fcnt", {30'd0, fail_cnt}, 32'd0);

`ifdef TTLOCK_KEY_PARITY_EN
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    send_key(GOOD, 1'b0, 1'b1);
    check("pe_pulse", {31'd0, parity_err}, 32'd1);
    check("pe_fcnt", {30'd0, fail_cnt}, 32'd0);
    check("pe_rdy", {31'd0, key_ready}, 32'd1);
    @(negedge clk);
    check("pe_unl", {31'd0, unlocked}, 32'd0);
    check("pe_kf", {31'd0, key_fail}, 32'd0);
    check("pe_end", {31'd0, parity_err}, 32'd0);
    send_key(GOOD, 1'b0, 1'b0);
    check("pg_nerr", {31'd0, parity_err}, 32'd0);
    @(negedge clk);
    check("pg_unl", {31'd0, unlocked}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
